// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared opcodes, FSM states, ctl/alu_op bit indices and ALU select decode.
// Package ctrl_pkg is imported by control_sequencer_if, instr_decode and control_sequencer.
package ctrl_pkg;
    localparam int ALU_W = 13;
    localparam int CTL_W = 14;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    localparam int C_PCOUT    = 0;
    localparam int C_PCIN     = 1;
    localparam int C_INCPC    = 2;
    localparam int C_MARIN    = 3;
    localparam int C_MDRIN    = 4;
    localparam int C_MDROUT   = 5;
    localparam int C_READ     = 6;
    localparam int C_IRIN     = 7;
    localparam int C_YIN      = 8;
    localparam int C_ZIN      = 9;
    localparam int C_ZLOWOUT  = 10;
    localparam int C_ZHIGHOUT = 11;
    localparam int C_HIIN     = 12;
    localparam int C_LOIN     = 13;

    localparam int A_AND  = 0;
    localparam int A_OR   = 1;
    localparam int A_ADD  = 2;
    localparam int A_SUB  = 3;
    localparam int A_MUL  = 4;
    localparam int A_DIV  = 5;
    localparam int A_SHR  = 6;
    localparam int A_SHRA = 7;
    localparam int A_SHL  = 8;
    localparam int A_ROR  = 9;
    localparam int A_ROL  = 10;
    localparam int A_NEG  = 11;
    localparam int A_NOT  = 12;

    // One-hot ALU select for an opcode; all-zero means the opcode is unsupported.
    function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
        alu_sel = '0;
        case (op)
            OP_ADD:  alu_sel[A_ADD]  = 1'b1;
            OP_SUB:  alu_sel[A_SUB]  = 1'b1;
            OP_AND:  alu_sel[A_AND]  = 1'b1;
            OP_OR:   alu_sel[A_OR]   = 1'b1;
            OP_ROR:  alu_sel[A_ROR]  = 1'b1;
            OP_ROL:  alu_sel[A_ROL]  = 1'b1;
            OP_SHR:  alu_sel[A_SHR]  = 1'b1;
            OP_SHRA: alu_sel[A_SHRA] = 1'b1;
            OP_SHL:  alu_sel[A_SHL]  = 1'b1;
            OP_MUL:  alu_sel[A_MUL]  = 1'b1;
            OP_DIV:  alu_sel[A_DIV]  = 1'b1;
            OP_NEG:  alu_sel[A_NEG]  = 1'b1;
            OP_NOT:  alu_sel[A_NOT]  = 1'b1;
            default: alu_sel = '0;
        endcase
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: sequencer bus bundle.
// Inputs to the sequencer: i_start, i_step, i_ir[31:0].
// Outputs from the sequencer: o_rout/o_rin[NUM_REGS-1:0], o_alu_op[12:0], o_ctl[13:0], o_busy, o_done, o_illegal.
interface control_sequencer_if import ctrl_pkg::*; #(parameter int NUM_REGS = 16);
    logic                i_start;
    logic                i_step;
    logic [31:0]         i_ir;
    logic [NUM_REGS-1:0] o_rout;
    logic [NUM_REGS-1:0] o_rin;
    logic [ALU_W-1:0]    o_alu_op;
    logic [CTL_W-1:0]    o_ctl;
    logic                o_busy;
    logic                o_done;
    logic                o_illegal;

    modport master (
        output i_start, i_step, i_ir,
        input  o_rout, o_rin, o_alu_op, o_ctl, o_busy, o_done, o_illegal
    );
    modport slave (
        input  i_start, i_step, i_ir,
        output o_rout, o_rin, o_alu_op, o_ctl, o_busy, o_done, o_illegal
    );
endinterface

// File: rtl/control_sequencer_decode.sv
// instr_decode: combinational IR decode into legality, unary/muldiv flags, ALU select and one-hot register selects.
// Ports: i_ir in; o_legal, o_unary, o_muldiv, o_alu_sel, o_ra_sel, o_rb_sel, o_rc_sel out.
module instr_decode import ctrl_pkg::*; #(parameter int NUM_REGS = 16) (
    input  logic [31:0]         i_ir,
    output logic                o_legal,
    output logic                o_unary,
    output logic                o_muldiv,
    output logic [ALU_W-1:0]    o_alu_sel,
    output logic [NUM_REGS-1:0] o_ra_sel,
    output logic [NUM_REGS-1:0] o_rb_sel,
    output logic [NUM_REGS-1:0] o_rc_sel
);
    logic w_unused_ir;

    assign o_alu_sel   = alu_sel(i_ir[31:27]);
    assign o_legal     = |o_alu_sel;
    assign o_unary     = o_alu_sel[A_NEG] | o_alu_sel[A_NOT];
    assign o_muldiv    = o_alu_sel[A_MUL] | o_alu_sel[A_DIV];
    assign o_ra_sel    = NUM_REGS'(1) << i_ir[26:23];
    assign o_rb_sel    = NUM_REGS'(1) << i_ir[22:19];
    assign o_rc_sel    = NUM_REGS'(1) << i_ir[18:15];
    assign w_unused_ir = ^i_ir[14:0];
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/execute control FSM (IDLE, T0..T6) driving register, ALU and bus controls.
// Ports: clk, reset (synchronous, active-low), bus (control_sequencer_if.slave).
// Optional macro CTRL_STEP_EN: T0..T6 advance only when i_step=1; done/illegal pulse once per state entry.
module control_sequencer import ctrl_pkg::*; #(parameter int NUM_REGS = 16) (
    input logic               clk,
    input logic               reset,
    control_sequencer_if.slave bus
);
    state_t              r_state, w_seq, w_next;
    logic                w_adv, w_first;
    logic                w_legal, w_unary, w_muldiv;
    logic [ALU_W-1:0]    w_alu_sel, w_alu;
    logic [NUM_REGS-1:0] w_ra_sel, w_rb_sel, w_rc_sel, w_rout, w_rin;
    logic [CTL_W-1:0]    w_ctl;
    logic                w_done, w_illegal;

    instr_decode #(.NUM_REGS(NUM_REGS)) u_decode (
        .i_ir      (bus.i_ir),
        .o_legal   (w_legal),
        .o_unary   (w_unary),
        .o_muldiv  (w_muldiv),
        .o_alu_sel (w_alu_sel),
        .o_ra_sel  (w_ra_sel),
        .o_rb_sel  (w_rb_sel),
        .o_rc_sel  (w_rc_sel)
    );

`ifdef CTRL_STEP_EN
    // r_first marks the first cycle in a state so stalled states do not repeat pulses.
    logic r_first;
    always_ff @(posedge clk) begin
        if (!reset) r_first <= 1'b0;
        else        r_first <= (w_next != r_state);
    end
    assign w_adv   = (r_state == S_IDLE) || bus.i_step;
    assign w_first = r_first;
`else
    logic w_unused_step;
    assign w_unused_step = bus.i_step;
    assign w_adv         = 1'b1;
    assign w_first       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_seq     = r_state;
        w_rout    = '0;
        w_rin     = '0;
        w_alu     = '0;
        w_ctl     = '0;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE: w_seq = bus.i_start ? S_T0 : S_IDLE;
            S_T0: begin
                w_ctl[C_PCOUT] = 1'b1;
                w_ctl[C_MARIN] = 1'b1;
                w_ctl[C_INCPC] = 1'b1;
                w_ctl[C_PCIN]  = 1'b1;
                w_seq          = S_T1;
            end
            S_T1: begin
                w_ctl[C_READ]  = 1'b1;
                w_ctl[C_MDRIN] = 1'b1;
                w_seq          = S_T2;
            end
            S_T2: begin
                w_ctl[C_MDROUT] = 1'b1;
                w_ctl[C_IRIN]   = 1'b1;
                w_seq           = S_T3;
            end
            S_T3: begin
                if (w_legal) begin
                    w_rout       = w_rb_sel;
                    w_ctl[C_YIN] = 1'b1;
                    w_seq        = S_T4;
                end else begin
                    w_illegal = w_first;
                    w_seq     = S_IDLE;
                end
            end
            S_T4: begin
                w_rout       = w_unary ? w_rb_sel : w_rc_sel;
                w_alu        = w_alu_sel;
                w_ctl[C_ZIN] = 1'b1;
                w_seq        = S_T5;
            end
            S_T5: begin
                w_ctl[C_ZLOWOUT] = 1'b1;
                w_ctl[C_LOIN]    = w_muldiv;
                w_rin            = w_muldiv ? '0 : w_ra_sel;
                w_done           = !w_muldiv && w_first;
                w_seq            = w_muldiv ? S_T6 : S_IDLE;
            end
            S_T6: begin
                w_ctl[C_ZHIGHOUT] = 1'b1;
                w_ctl[C_HIIN]     = 1'b1;
                w_done            = w_first;
                w_seq             = S_IDLE;
            end
            default: w_seq = S_IDLE;
        endcase
        w_next = w_adv ? w_seq : r_state;
    end

    assign bus.o_rout    = w_rout;
    assign bus.o_rin     = w_rin;
    assign bus.o_alu_op  = w_alu;
    assign bus.o_ctl     = w_ctl;
    assign bus.o_busy    = (r_state != S_IDLE);
    assign bus.o_done    = w_done;
    assign bus.o_illegal = w_illegal;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer (CTRL_STEP_EN optional).
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [61:0] obs;

    always #5 clk = ~clk;

    control_sequencer_if #(.NUM_REGS(16)) u_if ();
    control_sequencer #(.NUM_REGS(16)) dut (.clk(clk), .reset(reset), .bus(u_if.slave));

    assign obs = {u_if.o_rout, u_if.o_rin, u_if.o_alu_op, u_if.o_ctl, u_if.o_busy, u_if.o_done, u_if.o_illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        u_if.i_start = 1'b1;
        u_if.i_ir = 32'h4A1B8000;
        tick();
        tick();
        n_chk++;
        if (obs !== 62'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 62'd0);
        end
        u_if.i_start = 1'b0;
        reset = 1'b1;
        tick();
        n_chk++;
        if (obs !== 62'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h expected %h", obs, 62'd0);
        end
    endtask

    task automatic test_shr();
        logic [13:0] e_ctl [6] = '{14'h000F, 14'h0050, 14'h00A0, 14'h0100, 14'h0200, 14'h0400};
        logic [15:0] e_rout[6] = '{16'h0, 16'h0, 16'h0, 16'h0008, 16'h0080, 16'h0};
        logic [15:0] e_rin [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0010};
        logic [12:0] e_alu [6] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0040, 13'h0};
        logic        e_done[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [61:0] exp;
        u_if.i_ir = 32'h4A1B8000;
        u_if.i_start = 1'b1;
        tick();
        u_if.i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp = {e_rout[c], e_rin[c], e_alu[c], e_ctl[c], 1'b1, e_done[c], 1'b0};
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL shr_t%0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
        n_chk++;
        if (obs !== 62'd0) begin
            n_fail++;
            $display("FAIL shr_idle_after: got %h expected %h", obs, 62'd0);
        end
    endtask

    task automatic test_mul();
        logic [13:0] e_ctl [7] = '{14'h000F, 14'h0050, 14'h00A0, 14'h0100, 14'h0200, 14'h2400, 14'h1800};
        logic [15:0] e_rout[7] = '{16'h0, 16'h0, 16'h0, 16'h0008, 16'h0080, 16'h0, 16'h0};
        logic [12:0] e_alu [7] = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0010, 13'h0, 13'h0};
        logic        e_done[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [61:0] exp;
        u_if.i_ir = 32'h781B8000;
        u_if.i_start = 1'b1;
        tick();
        u_if.i_start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            exp = {e_rout[c], 16'h0, e_alu[c], e_ctl[c], 1'b1, e_done[c], 1'b0};
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mul_t%0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
        n_chk++;
        if (obs !== 62'd0) begin
            n_fail++;
            $display("FAIL mul_idle_after: got %h expected %h", obs, 62'd0);
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0] ops[11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                5'b01010, 5'b01011, 5'b10000, 5'b10001, 5'b10010};
        int         bits[11] = '{2, 3, 0, 1, 9, 10, 7, 8, 5, 11, 12};
        logic       un[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic       md[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            logic [3:0]  ra, rb, rc;
            logic [15:0] e_rout, e_rin;
            logic [13:0] e_ctl5;
            int          n;
            ra = 4'(i + 1);
            rb = 4'(i + 5);
            rc = 4'(i + 9);
            e_rout = 16'(1) << (un[i] ? rb : rc);
            e_rin = md[i] ? 16'h0 : 16'(1) << ra;
            e_ctl5 = md[i] ? 14'h2400 : 14'h0400;
            u_if.i_ir = mk(ops[i], ra, rb, rc);
            u_if.i_start = 1'b1;
            tick();
            u_if.i_start = 1'b0;
            repeat (4) tick();
            n_chk++;
            if ({u_if.o_alu_op, u_if.o_rout, u_if.o_ctl} !== {13'(1) << bits[i], e_rout, 14'h0200}) begin
                n_fail++;
                $display("FAIL alu_t4_op%0d: got %h/%h/%h expected %h/%h/%h", i, u_if.o_alu_op, u_if.o_rout,
                         u_if.o_ctl, 13'(1) << bits[i], e_rout, 14'h0200);
            end
            tick();
            n_chk++;
            if ({u_if.o_ctl, u_if.o_rin, u_if.o_done} !== {e_ctl5, e_rin, !md[i]}) begin
                n_fail++;
                $display("FAIL alu_t5_op%0d: got %h/%h/%b expected %h/%h/%b", i, u_if.o_ctl, u_if.o_rin,
                         u_if.o_done, e_ctl5, e_rin, !md[i]);
            end
            n = 0;
            while (u_if.o_busy && n < 4) begin
                tick();
                n++;
            end
            n_chk++;
            if (u_if.o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_return_idle_op%0d: got busy=%b expected busy=0", i, u_if.o_busy);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] irs[2] = '{32'hF8000000, 32'h00000000};
        logic [61:0] exp;
        logic [15:0] rin_seen;
        for (int i = 0; i < 2; i++) begin
            rin_seen = '0;
            exp = {16'h0, 16'h0, 13'h0, 14'h0, 1'b1, 1'b0, 1'b1};
            u_if.i_ir = irs[i];
            u_if.i_start = 1'b1;
            tick();
            u_if.i_start = 1'b0;
            repeat (3) begin
                rin_seen |= u_if.o_rin;
                tick();
            end
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL illegal_t3_%0d: got %h expected %h", i, obs, exp);
            end
            rin_seen |= u_if.o_rin;
            tick();
            rin_seen |= u_if.o_rin;
            n_chk++;
            if (obs !== 62'd0) begin
                n_fail++;
                $display("FAIL illegal_idle_%0d: got %h expected %h", i, obs, 62'd0);
            end
            n_chk++;
            if (rin_seen !== 16'h0) begin
                n_fail++;
                $display("FAIL illegal_rin_%0d: got %h expected %h", i, rin_seen, 16'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rin_seen = '0;
        logic        busy_seen = 1'b0;
        u_if.i_ir = mk(5'b00011, 4'd1, 4'd2, 4'd5);
        u_if.i_start = 1'b1;
        tick();
        u_if.i_start = 1'b0;
        repeat (4) tick();
        n_chk++;
        if ({u_if.o_rout, u_if.o_alu_op, u_if.o_ctl} !== {16'h0020, 13'h0004, 14'h0200}) begin
            n_fail++;
            $display("FAIL rstmid_t4: got %h/%h/%h expected %h/%h/%h", u_if.o_rout, u_if.o_alu_op, u_if.o_ctl,
                     16'h0020, 13'h0004, 14'h0200);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_chk++;
        if (obs !== 62'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h expected %h", obs, 62'd0);
        end
        repeat (8) begin
            tick();
            rin_seen |= u_if.o_rin;
            busy_seen |= u_if.o_busy;
        end
        n_chk++;
        if ({busy_seen, rin_seen} !== 17'd0) begin
            n_fail++;
            $display("FAIL rstmid_no_resume: got busy=%b rin=%h expected busy=0 rin=0", busy_seen, rin_seen);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int dones = 0;
        u_if.i_ir = 32'h4A1B8000;
        u_if.i_start = 1'b1;
        tick();
        while (u_if.o_busy && n < 12) begin
            dones += int'(u_if.o_done);
            tick();
            n++;
        end
        n_chk++;
        if ({n, dones} !== {32'd6, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got busy=%0d done=%0d expected busy=6 done=1", n, dones);
        end
        tick();
        n_chk++;
        if ({u_if.o_busy, u_if.o_ctl} !== {1'b1, 14'h000F}) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b ctl=%h expected busy=1 ctl=000f", u_if.o_busy, u_if.o_ctl);
        end
        u_if.i_start = 1'b0;
        n = 0;
        while (u_if.o_busy && n < 12) begin
            tick();
            n++;
        end
        n_chk++;
        if (n !== 6) begin
            n_fail++;
            $display("FAIL b2b_second_len: got %0d expected 6", n);
        end
    endtask

`ifdef CTRL_STEP_EN
    task automatic test_step();
        int dones = 0;
        u_if.i_ir = mk(5'b00011, 4'd1, 4'd2, 4'd5);
        u_if.i_step = 1'b1;
        u_if.i_start = 1'b1;
        tick();
        u_if.i_start = 1'b0;
        repeat (4) tick();
        u_if.i_step = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            dones += int'(u_if.o_done);
            n_chk++;
            if ({u_if.o_rout, u_if.o_alu_op, u_if.o_ctl, u_if.o_busy} !== {16'h0020, 13'h0004, 14'h0200, 1'b1}) begin
                n_fail++;
                $display("FAIL step_hold_t4_%0d: got %h/%h/%h/%b expected 0020/0004/0200/1", c, u_if.o_rout,
                         u_if.o_alu_op, u_if.o_ctl, u_if.o_busy);
            end
        end
        u_if.i_step = 1'b1;
        tick();
        dones += int'(u_if.o_done);
        n_chk++;
        if ({u_if.o_done, u_if.o_rin} !== {1'b1, 16'h0002}) begin
            n_fail++;
            $display("FAIL step_t5: got done=%b rin=%h expected done=1 rin=0002", u_if.o_done, u_if.o_rin);
        end
        u_if.i_step = 1'b0;
        tick();
        dones += int'(u_if.o_done);
        n_chk++;
        if ({u_if.o_done, u_if.o_rin, u_if.o_ctl} !== {1'b0, 16'h0002, 14'h0400}) begin
            n_fail++;
            $display("FAIL step_t5_held: got done=%b rin=%h ctl=%h expected done=0 rin=0002 ctl=0400",
                     u_if.o_done, u_if.o_rin, u_if.o_ctl);
        end
        u_if.i_step = 1'b1;
        tick();
        n_chk++;
        if ({u_if.o_busy, dones} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL step_single_done: got busy=%b dones=%0d expected busy=0 dones=1", u_if.o_busy, dones);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        u_if.i_start = 1'b0;
        u_if.i_ir = 32'h0;
`ifdef CTRL_STEP_EN
        u_if.i_step = 1'b1;
`else
        u_if.i_step = 1'b0;
`endif
        test_reset();
        test_shr();
        test_mul();
        test_alu_ops();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
`ifdef CTRL_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 16, number of general registers (Rout/Rin vector width).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  begin one fetch/execute cycle, sampled in IDLE only.
REQ-005 step  input  1  single-step advance enable (used only with CTRL_STEP_EN).
REQ-006 IR  input  32  instruction register contents from datapath.
REQ-007 Rout  output  NUM_REGS  one-hot general-register bus drive.
REQ-008 Rin  output  NUM_REGS  one-hot general-register load.
REQ-009 alu_op  output  13  one-hot ALU select: bit0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT.
REQ-010 ctl  output  14  bus controls: PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin (bit map in package).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse in final execute step.
REQ-013 illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-014 States: IDLE, T0..T6; one state per clock; all outputs Moore-decoded from state and IR.
REQ-015 Fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-016 Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010; all others illegal.
REQ-017 IDLE->T0 when start=1; start while busy ignored.
REQ-018 T0: PCout, MARin, IncPC, PCin.  T1: Read, MDRin.  T2: MDRout, IRin.
REQ-019 T3: op decoded from IR; legal: Rout[rb], Yin; illegal: no outputs except illegal=1, next state IDLE.
REQ-020 T4: binary ops Rout[rc], unary (NEG/NOT) Rout[rb]; alu_op bit for op; Zin.
REQ-021 T5: Zlowout; MUL/DIV assert LOin, others Rin[ra]; non-MUL/DIV assert done, next IDLE.
REQ-022 T6 (MUL/DIV only): Zhighout, HIin, done; next IDLE.
REQ-023 Latency start->done: 6 cycles non-MUL/DIV, 7 cycles MUL/DIV; start may re-assert in the IDLE cycle following done.
REQ-024 At most one Rout bit and one bus-driving ctl bit (PCout, MDRout, Zlowout, Zhighout) high in any cycle.

Reset
REQ-025 reset=0 at any clock edge, including mid-instruction: next state IDLE; Rout, Rin, alu_op, ctl all 0; busy, done, illegal 0.
REQ-026 Partial instruction aborted by reset is not resumed.

Configuration
REQ-027 CTRL_STEP_EN defined: T0..T6 advance only on cycles with step=1, outputs held while stalled; done/illegal pulse once per state entry.
REQ-028 CTRL_STEP_EN undefined: step ignored, one state per clock.

Structure
REQ-029 Package ctrl_pkg: opcode constants, state enum, ctl bit indices, alu_op bit indices.
REQ-030 Sub-module instr_decode: combinational IR -> op legality, unary/muldiv flags, one-hot ra/rb/rc selects.

Verification
REQ-031 start, IR=0x4A1B8000 (SHR, ra=R4, rb=R3, rc=R7) -> T3 Rout=0x0008+Yin; T4 Rout=0x0080, alu_op[6], Zin; T5 Zlowout, Rin=0x0010, done; busy 6 cycles.
REQ-032 start, IR=0x781B8000 (MUL rb=R3 rc=R7) -> T5 Zlowout+LOin, Rin=0; T6 Zhighout+HIin+done; busy 7 cycles.
REQ-033 IR=0xF8000000 -> illegal pulse at T3, Rin never nonzero, IDLE next cycle.
REQ-034 reset=0 during T4 of ADD -> all outputs 0 next cycle, IDLE, no Rin asserted.
REQ-035 start held high through an instruction -> exactly one new T0 after returning to IDLE; no restart while busy.
REQ-036 CTRL_STEP_EN: step=0 for 3 cycles in T4 -> outputs held, done delayed 3 cycles, single done pulse.
